seq1011_fsm: RTL and testbench
==============================

Name: seq1011_fsm

Overview:
- Serial Moore pattern detector that consumes the 1-bit-per-cycle stream held in the design's D-flip-flop stage and its state register.
- Detects the bit sequence 1,0,1,1 on input X, with overlapping matches allowed.
- Asserts Z for one state period per match and keeps a saturating count of matches.
- Sits directly downstream of the dff stage. The state register is built from the same posedge flip-flop semantics: D is sampled on the rising edge of clk, and Q is valid shortly after.

Parameters:
- COUNT_W, 4, width of the match counter (minimum 1)

Ports:
- clk  input  1  system clock; all state changes occur on the rising edge
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk
- en  input  1  advance enable; when 0, state and count hold
- X  input  1  serial data bit, sampled on the rising edge when en=1
- Z  output  1  Moore detect output, high only in state S4
- state  output  3  current state encoding, for debug and verification
- count  output  COUNT_W  number of matches detected since reset, saturating

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. There is no asynchronous reset path.
- Reset: a rising edge with rst=1 forces state=S0, Z=0 and count=0. This holds regardless of en and X. rst takes priority over every other event, including reset mid-sequence and reset in the same cycle a match would complete.
- State encoding:
  - S0=3'd0: no partial match
  - S1=3'd1: seen "1"
  - S2=3'd2: seen "10"
  - S3=3'd3: seen "101"
  - S4=3'd4: seen "1011"
- Transitions, applied on a rising edge when en=1 and rst=0:
  - S0: X=1 -> S1; X=0 -> S0
  - S1: X=1 -> S1; X=0 -> S2
  - S2: X=1 -> S3; X=0 -> S0
  - S3: X=1 -> S4; X=0 -> S2
  - S4: X=1 -> S1; X=0 -> S2 (overlap: suffixes "1" and "10" are retained)
- Illegal encodings 3'd5 to 3'd7 go to S0 on the next rising edge, whatever en and X are. count is unchanged on that edge.
- en=0: state and count hold. Z continues to reflect the held state, so a held S4 keeps Z=1.
- Z = (state==S4). It is a registered Moore output: no combinational path from X or en to Z.
- Latency: if the final "1" of a match is sampled at rising edge k, then Z=1 from just after edge k until just after edge k+1. With en=1, Z is high for exactly one clock period per match.
- count increments by 1 on every edge where the next state is S4 (en=1, rst=0).
  - It saturates at 2^COUNT_W-1 and never wraps.
  - It updates on the same edge that Z rises, so Z and the incremented count appear together.
- Back-to-back matches: "1011011" produces two matches, with Z high in cycles 4 and 7 after the first sampled bit.
- All outputs are defined (no X) from the first rising edge with rst=1 onward.
- Bench convention: drive X, en and rst on the falling edge; check outputs 1 time unit after the rising edge.

Test Plan:
1. Reset: rst=1 for 2 edges with X=1, en=1 -> state=0, Z=0, count=0. Release rst; drive X=1,0,1,1 -> state 1,2,3,4; Z=1 only after the 4th edge; count=1.
2. Overlap: X=1,0,1,1,0,1,1 with en=1 -> Z=1 after edges 4 and 7 only; state after edge 5 is 2; count=2.
3. Enable hold: X=1,0,1 then en=0 for 3 edges with X toggling -> state stays 3, count unchanged. Then en=1, X=1 -> state=4, Z=1. Then en=0 for 2 edges -> Z stays 1 and count stays 1.
4. Non-match and near-miss: X=1,1,1,0,0,1,0,1,1 -> states 1,1,1,2,0,1,2,3,4; exactly one Z pulse, after the 9th edge; count=1.
5. Saturation with COUNT_W=2: feed "1011" repeatedly, using overlap "011" after the first, for 5 matches -> count goes 1,2,3,3,3; Z still pulses on each match.
6. Reset mid-operation: reach S3, then assert rst on the edge where X=1 -> state=0, Z=0, count=0, and no Z pulse. Force state to 3'd6 via the bench -> state=0 after one edge.

Source files
------------

// File: rtl/seq1011_fsm_if.sv
// seq1011_fsm_if: serial bit stream in, detect flag/state/match count out
interface seq1011_fsm_if #(parameter int COUNT_W = 4);
  logic en;
  logic X;
  logic Z;
  logic [2:0] state;
  logic [COUNT_W-1:0] count;
  modport master(output en, X, input Z, state, count);
  modport slave(input en, X, output Z, state, count);
endinterface

// File: rtl/seq1011_fsm.sv
// seq1011_fsm: Moore detector for overlapping 1011 on X with saturating match count
module seq1011_fsm #(
  parameter int COUNT_W = 4
) (
  input logic clk,
  input logic rst,
  seq1011_fsm_if.slave bus
);
  typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4} state_t;
  logic [2:0] state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (state_q > S4) state_d = S0;
    else if (bus.en) begin
      case (state_q)
        S0: state_d = bus.X ? S1 : S0;
        S1: state_d = bus.X ? S1 : S2;
        S2: state_d = bus.X ? S3 : S0;
        S3: state_d = bus.X ? S4 : S2;
        default: state_d = bus.X ? S1 : S2;
      endcase
      count_d = (state_d == S4 && count_q != '1) ? count_q + 1'b1 : count_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  assign bus.Z = (state_q == S4);
  assign bus.state = state_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_seq1011_fsm.sv
// tb_seq1011_fsm: directed scoreboard bench for COUNT_W=4 and a saturating COUNT_W=2 copy
module tb_seq1011_fsm;
  logic clk, rst, en, x;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [2:0] s;
    logic [3:0] c;
  } exp_t;
  exp_t sb[$];
  seq1011_fsm_if #(.COUNT_W(4)) bif();
  seq1011_fsm_if #(.COUNT_W(2)) bif2();
  assign bif.en = en;
  assign bif.X = x;
  assign bif2.en = en;
  assign bif2.X = x;
  seq1011_fsm #(.COUNT_W(4)) dut(.clk(clk), .rst(rst), .bus(bif));
  seq1011_fsm #(.COUNT_W(2)) dut2(.clk(clk), .rst(rst), .bus(bif2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic xx,
                      input logic [2:0] es, input logic [3:0] ec, input bit inj);
    exp_t ex;
    @(negedge clk);
    rst = r;
    en = e;
    x = xx;
    if (inj) begin
      force dut.state_q = 3'd6;
      force dut2.state_q = 3'd6;
      #1;
      release dut.state_q;
      release dut2.state_q;
    end
    ex.s = es;
    ex.c = ec;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 4'd1, 4'd0);
    end else begin
      ex = sb.pop_front();
      chk("state", {1'b0, bif.state}, {1'b0, ex.s});
      chk("z", {3'b0, bif.Z}, {3'b0, ex.s == 3'd4});
      chk("count", bif.count, ex.c);
      chk("state_w2", {1'b0, bif2.state}, {1'b0, ex.s});
      chk("z_w2", {3'b0, bif2.Z}, {3'b0, ex.s == 3'd4});
      chk("count_w2", {2'b0, bif2.count}, (ex.c > 4'd3) ? 4'd3 : ex.c);
    end
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b1;
    x = 1'b1;
    // reset then a single match
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    step(0, 1, 1, 4, 1, 0);
    // overlapping matches 1011011
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    step(0, 1, 1, 4, 1, 0);
    step(0, 1, 0, 2, 1, 0);
    step(0, 1, 1, 3, 1, 0);
    step(0, 1, 1, 4, 2, 0);
    // enable hold in S3 and in S4
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 3, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 1, 1, 4, 1, 0);
    step(0, 0, 0, 4, 1, 0);
    step(0, 0, 1, 4, 1, 0);
    // near misses 111001011
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    step(0, 1, 1, 4, 1, 0);
    // five overlapping matches: narrow counter saturates at 3
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    step(0, 1, 1, 4, 1, 0);
    for (int i = 2; i <= 5; i++) begin
      step(0, 1, 0, 2, 4'(i - 1), 0);
      step(0, 1, 1, 3, 4'(i - 1), 0);
      step(0, 1, 1, 4, 4'(i), 0);
    end
    // reset wins over a completing match
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    // illegal encoding recovers to S0 without counting
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    step(0, 1, 1, 4, 1, 0);
    step(0, 1, 0, 2, 1, 0);
    step(0, 1, 1, 3, 1, 0);
    step(0, 1, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
